vend_ctrl: RTL and testbench
============================

Name: vend_ctrl

Overview:
Top-level vending machine sequencer. Takes debounced product-select, coin and cancel pulses; tracks selection, credit and per-product stock; drives the dispense, change and refund outputs. Produces ps/curr_prod/curr_price/money, which feed the seven-segment display driver directly. Runs on the 1 ms tick clock.

Parameters:
PRICE_A, 5, price of product A (4-bit, 1..15)
PRICE_B, 7, price of product B
PRICE_C, 10, price of product C
PRICE_D, 12, price of product D
PRICE_E, 15, price of product E
INIT_STOCK, 3, units per product loaded at reset and on restock (0..15)
TIMEOUT_TICKS, 10000, idle ticks in ProdSel/AmtSel before abort
HOLD_TICKS, 2000, ticks spent in Disp/Chng/Refund/Stock before returning to Reset

Ports:
clk_1ms  in  1  1 ms system clock
rst  in  1  synchronous, active-high reset
prod_btn  in  5  one-cycle pulses; bit0=A ... bit4=E
coin  in  3  one-cycle pulses; bit0=1, bit1=2, bit2=5 units
cancel  in  1  one-cycle pulse
restock  in  1  one-cycle pulse, honoured only in Reset
ps  out  3  state code, 0..6
curr_prod  out  4  selected product code 4'hA..4'hE; 0 when none
curr_price  out  4  price of curr_prod
money  out  4  accumulated credit
dispense  out  1  one-cycle pulse, vend curr_prod
change_val  out  4  change/refund amount, valid with change_stb
change_stb  out  1  one-cycle pulse
coin_reject  out  1  one-cycle pulse, returns the coin(s) of this cycle
led  out  4  {coin_reject sticky, dispense sticky, change sticky, stock-empty-any}

Behaviour:
- Clock and reset: single clock clk_1ms. Reset is synchronous, active-high. All outputs zero on reset; stock[A..E]=INIT_STOCK; tick counter=0.
- State codes: Reset=0, ProdSel=1, AmtSel=2, Disp=3, Chng=4, Refund=5, Stock=6. Other codes are illegal and go to Reset on the next cycle.
- Multiple prod_btn bits set: the lowest index wins. Coin input not one-hot: all coins that cycle are rejected.
- Reset:
  - prod_btn with stock>0 -> ProdSel; load curr_prod and curr_price.
  - prod_btn with stock==0 -> Stock; load curr_prod.
  - coin -> coin_reject.
  - restock -> all stock=INIT_STOCK.
- ProdSel:
  - prod_btn -> reselect, applying the same stock rule; tick counter clears.
  - Valid coin -> AmtSel; money=coin value.
  - cancel or TIMEOUT_TICKS with no input -> Reset; clear curr_prod and curr_price.
- AmtSel:
  - Valid coin: if money+value>15, coin_reject and money unchanged; otherwise money+=value.
  - If the post-add money>=curr_price, go the next cycle to Disp (equal) or Chng (greater).
  - prod_btn ignored.
  - cancel -> Refund. A coin in the same cycle as cancel is rejected.
  - TIMEOUT -> Refund.
  - Tick counter clears on every accepted coin.
- Disp: on the entry cycle, dispense=1 and stock[curr_prod]-=1.
- Chng: on the entry cycle, dispense=1, stock-=1, change_stb=1, change_val=money-curr_price. money stays held for the display.
- Refund: on the entry cycle, change_stb=1, change_val=money.
- Disp/Chng/Refund/Stock exit: after HOLD_TICKS -> Reset; clear money, curr_prod and curr_price. Inputs are ignored except that coins are rejected.
- Latency: output registers update one cycle after the input pulse. There is no combinational input-to-output path.
- Stock never underflows. A product with stock 0 cannot reach Disp.
- rst asserted mid-vend aborts with no dispense and no change pulse.
- led sticky bits clear on entry to Reset.
- led[0] = OR of (stock==0) over all products, updated combinationally from the stock registers.

Decomposition:
- Package vend_pkg: state code localparams (shared with the display driver), product codes 4'hA..4'hE, coin value constants.
- Sub-module vend_timer: tick counter with clear, a timeout compare and a hold compare; sized by $clog2(TIMEOUT_TICKS+1).

Test Plan:
- Exact pay: TIMEOUT_TICKS=20, HOLD_TICKS=5. prod_btn=A, then coin 5 -> ps 1->2->3; one dispense pulse; stock A 3->2; ps=0 after 5 ticks; money=0.
- Overpay: select D (12), coins 5,5,5 -> money 15; Chng; change_stb with change_val=3; dispense=1.
- Overflow and cancel: select E (15), coins 5,5,2,5 -> last coin rejected, money=12. Then cancel and coin in the same cycle -> coin_reject, Refund, change_val=12.
- Sold out: vend B three times, then select B -> ps=6, curr_prod=4'hB, led[0]=1. restock in Reset -> led[0]=0.
- Timeout: select C, coin 2, idle 20 ticks -> Refund with change_val=2. Select C with no coin, idle 20 ticks -> Reset, no change_stb.
- Reset mid-operation: rst in AmtSel with money=7 -> next cycle all outputs 0, no pulses.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared constants for the vending machine sequencer: state
//                codes (also consumed by the display driver), product codes,
//                coin values and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    // State codes as seen on the ps output
    localparam logic [2:0] c_ST_RESET   = 3'd0;
    localparam logic [2:0] c_ST_PRODSEL = 3'd1;
    localparam logic [2:0] c_ST_AMTSEL  = 3'd2;
    localparam logic [2:0] c_ST_DISP    = 3'd3;
    localparam logic [2:0] c_ST_CHNG    = 3'd4;
    localparam logic [2:0] c_ST_REFUND  = 3'd5;
    localparam logic [2:0] c_ST_STOCK   = 3'd6;

    typedef enum logic [2:0] {
        ST_RESET   = c_ST_RESET,
        ST_PRODSEL = c_ST_PRODSEL,
        ST_AMTSEL  = c_ST_AMTSEL,
        ST_DISP    = c_ST_DISP,
        ST_CHNG    = c_ST_CHNG,
        ST_REFUND  = c_ST_REFUND,
        ST_STOCK   = c_ST_STOCK
    } vend_state_e;

    // Product codes shown on the display; A..E are consecutive
    localparam logic [3:0] c_PROD_NONE = 4'h0;
    localparam logic [3:0] c_PROD_A    = 4'hA;
    localparam logic [3:0] c_PROD_B    = 4'hB;
    localparam logic [3:0] c_PROD_C    = 4'hC;
    localparam logic [3:0] c_PROD_D    = 4'hD;
    localparam logic [3:0] c_PROD_E    = 4'hE;
    localparam int         c_NUM_PROD  = 5;

    // Coin values in credit units
    localparam logic [3:0] c_COIN_1 = 4'd1;
    localparam logic [3:0] c_COIN_2 = 4'd2;
    localparam logic [3:0] c_COIN_5 = 4'd5;

    // Value of a coin pulse vector; zero when it is not exactly one coin
    function automatic logic [3:0] coin_value(input logic [2:0] coin);
        case (coin)
            3'b001:  coin_value = c_COIN_1;
            3'b010:  coin_value = c_COIN_2;
            3'b100:  coin_value = c_COIN_5;
            default: coin_value = 4'd0;
        endcase
    endfunction

    // Index of the lowest set product button (lowest index wins)
    function automatic logic [2:0] lowest_prod(input logic [4:0] btn);
        lowest_prod = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (btn[i]) begin
                lowest_prod = 3'(i);
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_timer.sv
`default_nettype none
// ============================================================================
//  Module      : vend_timer
//  Description : Idle/hold tick counter with synchronous clear. Flags the last
//                tick of the idle timeout window and of the hold window so the
//                sequencer can leave the state on that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_timer #(
    parameter int TIMEOUT_TICKS = 10000,
    parameter int HOLD_TICKS    = 2000
) (
    input  logic clk_1ms,
    input  logic rst,
    input  logic clr,
    output logic timeout,
    output logic hold_done
);

    localparam int             c_CW        = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_CW-1:0] c_TO_LAST   = c_CW'(TIMEOUT_TICKS - 1);
    localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(HOLD_TICKS - 1);

    logic [c_CW-1:0] r_count;

    // Count ticks since the last clear, saturating at full scale
    always_ff @(posedge clk_1ms) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign timeout   = (r_count == c_TO_LAST);
    assign hold_done = (r_count == c_HOLD_LAST);

endmodule
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vend_ctrl
//  Description : Vending machine sequencer. Tracks selection, credit and
//                per-product stock; issues dispense, change/refund and coin
//                reject pulses. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE_A       = 5,
    parameter int PRICE_B       = 7,
    parameter int PRICE_C       = 10,
    parameter int PRICE_D       = 12,
    parameter int PRICE_E       = 15,
    parameter int INIT_STOCK    = 3,
    parameter int TIMEOUT_TICKS = 10000,
    parameter int HOLD_TICKS    = 2000
) (
    input  logic       clk_1ms,
    input  logic       rst,
    input  logic [4:0] prod_btn,
    input  logic [2:0] coin,
    input  logic       cancel,
    input  logic       restock,
    output logic [2:0] ps,
    output logic [3:0] curr_prod,
    output logic [3:0] curr_price,
    output logic [3:0] money,
    output logic       dispense,
    output logic [3:0] change_val,
    output logic       change_stb,
    output logic       coin_reject,
    output logic [3:0] led
);

    function automatic logic [3:0] price_of(input logic [2:0] idx);
        case (idx)
            3'd0:    price_of = 4'(PRICE_A);
            3'd1:    price_of = 4'(PRICE_B);
            3'd2:    price_of = 4'(PRICE_C);
            3'd3:    price_of = 4'(PRICE_D);
            3'd4:    price_of = 4'(PRICE_E);
            default: price_of = 4'd0;
        endcase
    endfunction

    vend_state_e r_state, w_state_nxt;
    logic [3:0]  r_money, w_money_nxt;
    logic [3:0]  r_curr_prod, w_prod_nxt;
    logic [3:0]  r_curr_price, w_price_nxt;
    logic [2:0]  r_sel_idx, w_idx_nxt;
    logic        r_dispense, w_dispense_nxt;
    logic        r_change_stb, w_stb_nxt;
    logic [3:0]  r_change_val, w_cval_nxt;
    logic        r_coin_reject, w_reject_nxt;
    logic        r_led_rej, r_led_disp, r_led_chg;
    logic        w_timer_clr, w_restock, w_stock_dec;
    logic        w_timeout, w_hold_done, w_entering_reset;

    logic [c_NUM_PROD-1:0][3:0] w_stock;
    logic [c_NUM_PROD-1:0]      w_empty;

    logic        w_coin_any, w_btn_any;
    logic [3:0]  w_coin_val;
    logic [4:0]  w_sum;
    logic [2:0]  w_btn_idx;
    logic [3:0]  w_btn_code;

    assign w_coin_any = |coin;
    assign w_coin_val = coin_value(coin);
    assign w_sum      = {1'b0, r_money} + {1'b0, w_coin_val};
    assign w_btn_any  = |prod_btn;
    assign w_btn_idx  = lowest_prod(prod_btn);
    assign w_btn_code = c_PROD_A + {1'b0, w_btn_idx};

    vend_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .HOLD_TICKS    (HOLD_TICKS)
    ) u_timer (
        .clk_1ms   (clk_1ms),
        .rst       (rst),
        .clr       (w_timer_clr),
        .timeout   (w_timeout),
        .hold_done (w_hold_done)
    );

    // Per-product stock counters; decrement is guarded so stock never wraps
    generate
        for (genvar gi = 0; gi < c_NUM_PROD; gi++) begin : g_stock
            logic [3:0] r_stock_cnt;
            // Load on reset/restock, drop one unit when this product vends
            always_ff @(posedge clk_1ms) begin
                if (rst || w_restock) begin
                    r_stock_cnt <= 4'(INIT_STOCK);
                end else if (w_stock_dec && (r_sel_idx == 3'(gi)) && (r_stock_cnt != 4'd0)) begin
                    r_stock_cnt <= r_stock_cnt - 4'd1;
                end
            end
            assign w_stock[gi] = r_stock_cnt;
            assign w_empty[gi] = (r_stock_cnt == 4'd0);
        end
    endgenerate

    // Next-state and next-output decode for the sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_money_nxt    = r_money;
        w_prod_nxt     = r_curr_prod;
        w_price_nxt    = r_curr_price;
        w_idx_nxt      = r_sel_idx;
        w_dispense_nxt = 1'b0;
        w_stb_nxt      = 1'b0;
        w_cval_nxt     = 4'd0;
        w_reject_nxt   = 1'b0;
        w_timer_clr    = 1'b0;
        w_restock      = 1'b0;
        w_stock_dec    = 1'b0;

        case (r_state)
            ST_RESET: begin
                if (w_btn_any) begin
                    w_prod_nxt = w_btn_code;
                    w_idx_nxt  = w_btn_idx;
                    if (w_stock[w_btn_idx] != 4'd0) begin
                        w_state_nxt = ST_PRODSEL;
                        w_price_nxt = price_of(w_btn_idx);
                    end else begin
                        w_state_nxt = ST_STOCK;
                    end
                end
                w_reject_nxt = w_coin_any;
                w_restock    = restock;
            end

            ST_PRODSEL: begin
                w_timer_clr = w_btn_any | w_coin_any | cancel;
                if (cancel) begin
                    w_state_nxt  = ST_RESET;
                    w_prod_nxt   = c_PROD_NONE;
                    w_price_nxt  = 4'd0;
                    w_reject_nxt = w_coin_any;
                end else if (w_btn_any) begin
                    // Reselect: coins arriving alongside a button are returned
                    w_prod_nxt   = w_btn_code;
                    w_idx_nxt    = w_btn_idx;
                    w_reject_nxt = w_coin_any;
                    if (w_stock[w_btn_idx] != 4'd0) begin
                        w_price_nxt = price_of(w_btn_idx);
                    end else begin
                        w_state_nxt = ST_STOCK;
                        w_price_nxt = 4'd0;
                    end
                end else if (w_coin_any) begin
                    if (w_coin_val != 4'd0) begin
                        w_state_nxt = ST_AMTSEL;
                        w_money_nxt = w_coin_val;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_RESET;
                    w_prod_nxt  = c_PROD_NONE;
                    w_price_nxt = 4'd0;
                end
            end

            ST_AMTSEL: begin
                // Credit reached the price on the previous edge: vend now
                if (r_money >= r_curr_price) begin
                    w_dispense_nxt = 1'b1;
                    w_stock_dec    = 1'b1;
                    w_reject_nxt   = w_coin_any;
                    if (r_money == r_curr_price) begin
                        w_state_nxt = ST_DISP;
                    end else begin
                        w_state_nxt = ST_CHNG;
                        w_stb_nxt   = 1'b1;
                        w_cval_nxt  = r_money - r_curr_price;
                    end
                end else if (cancel || (!w_coin_any && w_timeout)) begin
                    w_state_nxt  = ST_REFUND;
                    w_stb_nxt    = 1'b1;
                    w_cval_nxt   = r_money;
                    w_reject_nxt = w_coin_any;
                end else if (w_coin_any) begin
                    if ((w_coin_val != 4'd0) && (w_sum <= 5'd15)) begin
                        w_money_nxt = w_sum[3:0];
                        w_timer_clr = 1'b1;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end

            ST_DISP, ST_CHNG, ST_REFUND, ST_STOCK: begin
                w_reject_nxt = w_coin_any;
                if (w_hold_done) begin
                    w_state_nxt = ST_RESET;
                    w_money_nxt = 4'd0;
                    w_prod_nxt  = c_PROD_NONE;
                    w_price_nxt = 4'd0;
                end
            end

            default: begin
                w_state_nxt = ST_RESET;
                w_money_nxt = 4'd0;
                w_prod_nxt  = c_PROD_NONE;
                w_price_nxt = 4'd0;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_timer_clr = 1'b1;
        end
    end

    assign w_entering_reset = (w_state_nxt == ST_RESET) && (r_state != ST_RESET);

    // Sequencer state, datapath and output registers
    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            r_state       <= ST_RESET;
            r_money       <= 4'd0;
            r_curr_prod   <= c_PROD_NONE;
            r_curr_price  <= 4'd0;
            r_sel_idx     <= 3'd0;
            r_dispense    <= 1'b0;
            r_change_stb  <= 1'b0;
            r_change_val  <= 4'd0;
            r_coin_reject <= 1'b0;
            r_led_rej     <= 1'b0;
            r_led_disp    <= 1'b0;
            r_led_chg     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_money       <= w_money_nxt;
            r_curr_prod   <= w_prod_nxt;
            r_curr_price  <= w_price_nxt;
            r_sel_idx     <= w_idx_nxt;
            r_dispense    <= w_dispense_nxt;
            r_change_stb  <= w_stb_nxt;
            r_change_val  <= w_cval_nxt;
            r_coin_reject <= w_reject_nxt;
            r_led_rej     <= (r_led_rej  & ~w_entering_reset) | w_reject_nxt;
            r_led_disp    <= (r_led_disp & ~w_entering_reset) | w_dispense_nxt;
            r_led_chg     <= (r_led_chg  & ~w_entering_reset) | w_stb_nxt;
        end
    end

    assign ps          = r_state;
    assign curr_prod   = r_curr_prod;
    assign curr_price  = r_curr_price;
    assign money       = r_money;
    assign dispense    = r_dispense;
    assign change_val  = r_change_val;
    assign change_stb  = r_change_stb;
    assign coin_reject = r_coin_reject;
    assign led         = {r_led_rej, r_led_disp, r_led_chg, |w_empty};

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vend_ctrl
//  Description : Bench for vend_ctrl. Sessions are modelled at transaction
//                level (credit arithmetic, stock counts); expected pulses go
//                into a queue and a monitor matches them as the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl;

    localparam int TO   = 20;
    localparam int HOLD = 5;
    localparam int INIT = 3;
    localparam int K_REJ  = 0;
    localparam int K_DISP = 1;
    localparam int K_CHG  = 2;

    logic       clk_1ms = 1'b0;
    logic       rst;
    logic [4:0] prod_btn;
    logic [2:0] coin;
    logic       cancel;
    logic       restock;
    logic [2:0] ps;
    logic [3:0] curr_prod, curr_price, money, change_val, led;
    logic       dispense, change_stb, coin_reject;

    vend_ctrl #(
        .TIMEOUT_TICKS (TO),
        .HOLD_TICKS    (HOLD)
    ) dut (
        .clk_1ms     (clk_1ms),
        .rst         (rst),
        .prod_btn    (prod_btn),
        .coin        (coin),
        .cancel      (cancel),
        .restock     (restock),
        .ps          (ps),
        .curr_prod   (curr_prod),
        .curr_price  (curr_price),
        .money       (money),
        .dispense    (dispense),
        .change_val  (change_val),
        .change_stb  (change_stb),
        .coin_reject (coin_reject),
        .led         (led)
    );

    always #5 clk_1ms = ~clk_1ms;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk_1ms) cyc <= cyc + 1;

    typedef struct { int kind; int val; } ev_t;
    ev_t exp_q[$];
    int  fq[$];       // forced coin values for directed sessions
    int  stock[5];
    int  mmoney;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic exp_push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected pulse: got kind %0d val %0d expected none (t=%0t)", kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            check("pulse kind", kind, e.kind);
            check("pulse value", val, e.val);
        end
    endtask

    // Monitor: match every output pulse against the expectation queue
    always @(negedge clk_1ms) begin
        if (coin_reject === 1'b1) pop_cmp(K_REJ, 0);
        if (dispense    === 1'b1) pop_cmp(K_DISP, int'(curr_prod));
        if (change_stb  === 1'b1) pop_cmp(K_CHG, int'(change_val));
    end

    function automatic int price_tb(input int p);
        case (p)
            0:       price_tb = 5;
            1:       price_tb = 7;
            2:       price_tb = 10;
            3:       price_tb = 12;
            default: price_tb = 15;
        endcase
    endfunction

    function automatic logic [2:0] pat(input int v);
        case (v)
            1:       pat = 3'b001;
            2:       pat = 3'b010;
            5:       pat = 3'b100;
            default: pat = 3'b011;
        endcase
    endfunction

    function automatic int rand_coin();
        int r;
        r = $urandom_range(0, 2);
        rand_coin = (r == 0) ? 1 : ((r == 1) ? 2 : 5);
    endfunction

    function automatic int any_empty();
        any_empty = 0;
        for (int i = 0; i < 5; i++) if (stock[i] == 0) any_empty = 1;
    endfunction

    task automatic drive(input logic [4:0] b, input logic [2:0] c, input logic cn, input logic rs);
        prod_btn = b;
        coin     = c;
        cancel   = cn;
        restock  = rs;
        @(negedge clk_1ms);
        prod_btn = '0;
        coin     = '0;
        cancel   = 1'b0;
        restock  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk_1ms);
        @(negedge clk_1ms);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) stock[i] = INIT;
    endtask

    // Called on the first cycle of a hold state; follows it back to Reset
    task automatic wait_hold(input int st);
        int n;
        check("hold state", int'(ps), st);
        n = 1;
        for (int i = 0; i < HOLD + 5; i++) begin
            @(negedge clk_1ms);
            if (ps == 3'd0) break;
            n++;
        end
        check("hold ticks", n, HOLD);
        check("money after hold", int'(money), 0);
        check("curr_prod after hold", int'(curr_prod), 0);
        check("curr_price after hold", int'(curr_price), 0);
        check("sticky leds after hold", int'(led[3:1]), 0);
        if (ps != 3'd0) begin
            exp_q.delete();
            do_reset();
        end
    endtask

    // end_kind: 0 pay in full, 1 cancel, 2 timeout, 3 cancel with a coin
    task automatic session(input int p, input int end_kind, input int max_coins);
        logic [4:0] btn;
        logic [2:0] c;
        int pr, v, nc, clr_edge, exp_st;
        bit in_amt;
        btn = 5'(1 << p);
        if (fq.size() == 0 && $urandom_range(0, 3) == 0)
            for (int j = p + 1; j < 5; j++) if ($urandom_range(0, 1) == 1) btn[j] = 1'b1;
        check("stock-empty led before select", int'(led[0]), any_empty());
        drive(btn, 3'b000, 1'b0, 1'b0);
        clr_edge = cyc;
        check("curr_prod on select", int'(curr_prod), 10 + p);
        if (stock[p] == 0) begin
            check("sold-out led", int'(led[0]), 1);
            check("sold-out price", int'(curr_price), 0);
            wait_hold(6);
            return;
        end
        pr = price_tb(p);
        check("ps after select", int'(ps), 1);
        check("curr_price on select", int'(curr_price), pr);
        mmoney = 0;
        in_amt = 0;
        if (fq.size() > 0) nc = fq.size();
        else if (end_kind == 0) nc = 100;
        else nc = $urandom_range(0, max_coins);
        for (int k = 0; k < nc; k++) begin
            if (in_amt && mmoney >= pr) break;
            if (fq.size() > 0) v = fq.pop_front();
            else if (in_amt && $urandom_range(0, 7) == 0) v = 0;
            else v = rand_coin();
            c = pat(v);
            if (!in_amt) begin
                drive(5'b0, c, 1'b0, 1'b0);
                in_amt   = 1;
                mmoney   = v;
                clr_edge = cyc;
                check("ps after first coin", int'(ps), 2);
            end else if (v == 0 || mmoney + v > 15) begin
                exp_push(K_REJ, 0);
                drive(5'b0, c, 1'b0, 1'b0);
            end else begin
                mmoney += v;
                drive(5'b0, c, 1'b0, 1'b0);
                clr_edge = cyc;
            end
            check("money after coin", int'(money), mmoney);
        end
        if (in_amt && mmoney >= pr) begin
            exp_push(K_DISP, 10 + p);
            if (mmoney > pr) exp_push(K_CHG, mmoney - pr);
            stock[p]--;
            @(negedge clk_1ms);
            check("dispense led", int'(led[2]), 1);
            check("change led", int'(led[1]), (mmoney > pr) ? 1 : 0);
            check("money held in vend", int'(money), mmoney);
            wait_hold((mmoney == pr) ? 3 : 4);
        end else if (end_kind == 1 || end_kind == 3) begin
            c = (end_kind == 3) ? pat(rand_coin()) : 3'b000;
            if (end_kind == 3) exp_push(K_REJ, 0);
            if (in_amt) begin
                exp_push(K_CHG, mmoney);
                drive(5'b0, c, 1'b1, 1'b0);
                wait_hold(5);
            end else begin
                drive(5'b0, c, 1'b1, 1'b0);
                check("ps after cancel", int'(ps), 0);
                check("curr_prod after cancel", int'(curr_prod), 0);
                check("curr_price after cancel", int'(curr_price), 0);
            end
        end else begin
            exp_st = in_amt ? 2 : 1;
            if (in_amt) exp_push(K_CHG, mmoney);
            for (int i = 0; i < 3 * TO; i++) begin
                @(negedge clk_1ms);
                if (int'(ps) != exp_st) break;
            end
            check("timeout ticks", cyc - clr_edge, TO);
            if (in_amt) begin
                wait_hold(5);
            end else begin
                check("ps after timeout", int'(ps), 0);
                check("curr_prod after timeout", int'(curr_prod), 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        logic [2:0] c;
        prod_btn = '0;
        coin     = '0;
        cancel   = 1'b0;
        restock  = 1'b0;
        do_reset();
        check("reset ps", int'(ps), 0);
        check("reset curr_prod", int'(curr_prod), 0);
        check("reset curr_price", int'(curr_price), 0);
        check("reset money", int'(money), 0);
        check("reset pulses", int'({dispense, change_stb, coin_reject}), 0);
        check("reset change_val", int'(change_val), 0);
        check("reset led", int'(led), 0);

        // Exact pay for A
        fq = '{5};
        session(0, 0, 0);
        // Overpay for D: 15 credit, 3 change
        fq = '{5, 5, 5};
        session(3, 0, 0);
        // Overflow on E, then cancel with a coin in the same cycle
        fq = '{5, 5, 2, 5};
        session(4, 3, 0);
        // Sell out B, then select it again, then restock
        for (int i = 0; i < 3; i++) begin
            fq = '{5, 2};
            session(1, 0, 0);
        end
        session(1, 0, 0);
        drive(5'b0, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) stock[i] = INIT;
        check("stock-empty led after restock", int'(led[0]), 0);
        // Timeouts: with credit, then without
        fq = '{2};
        session(2, 2, 0);
        session(2, 2, 0);
        // Reset in the middle of a payment
        fq = '{5, 2};
        drive(5'b10000, 3'b000, 1'b0, 1'b0);
        drive(5'b0, pat(5), 1'b0, 1'b0);
        drive(5'b0, pat(2), 1'b0, 1'b0);
        fq.delete();
        check("money before abort", int'(money), 7);
        rst = 1'b1;
        @(negedge clk_1ms);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) stock[i] = INIT;
        check("abort outputs", int'({ps, curr_prod, curr_price, money, change_val, led}), 0);
        check("abort pulses", int'({dispense, change_stb, coin_reject}), 0);
        repeat (3) @(negedge clk_1ms);
        check("ps idle after abort", int'(ps), 0);

        // Randomized sessions
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                drive(5'b0, 3'b000, 1'b0, 1'b1);
                for (int i = 0; i < 5; i++) stock[i] = INIT;
                check("stock-empty led after restock", int'(led[0]), 0);
            end
            if ($urandom_range(0, 5) == 0) begin
                c = 3'($urandom_range(1, 7));
                exp_push(K_REJ, 0);
                drive(5'b0, c, 1'b0, 1'b0);
            end
            session($urandom_range(0, 4), $urandom_range(0, 3), 4);
        end

        repeat (3) @(negedge clk_1ms);
        check("pending expected pulses", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
